// File: rtl/axil_reg_slave_pkg.sv
// Shared AXI-Lite response codes and FSM state types for the register slave.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_A,
    W_GOT_D,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/axil_reg_slave_bank.sv
// Register array with byte-strobe write port, asynchronous read mux and
// one-cycle per-register update strobes.
module axil_reg_bank #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned         IDX_W      = $clog2(NUM_REGS),
  localparam int unsigned         STRB_W     = DATA_WIDTH / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic [IDX_W-1:0]               widx_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [STRB_W-1:0]              wstrb_i,
  input  logic [IDX_W-1:0]               ridx_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= RESET_VAL;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (we_i) begin
        for (int unsigned b = 0; b < STRB_W; b++)
          if (wstrb_i[b]) mem_q[widx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        wr_pulse_q[widx_i] <= 1'b1;
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
  end

  assign rdata_o    = mem_q[ridx_i];
  assign wr_pulse_o = wr_pulse_q;

endmodule

// File: rtl/axil_reg_slave.sv
// AXI-Lite slave register bank; one outstanding write and one outstanding read.
// Optional AXIL_REG_PROT_CHECK_EN rejects unprivileged (AWPROT[0]=0) writes.
module axil_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] hi;
    hi = a >> (LSB + IDX_W);
    return (32'(a[LSB +: IDX_W]) >= NUM_REGS) || (hi != '0);
  endfunction

  wr_state_t             wst_q, wst_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [2:0]            awprot_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  resp_t                 bresp_q;

  logic aw_hs, w_hs, commit, w_err, prot_err, bank_we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic [STRB_W-1:0]     ws;
  logic [2:0]            wp;

  assign AWREADY = ~ARESET & ((wst_q == W_IDLE) | (wst_q == W_GOT_D));
  assign WREADY  = ~ARESET & ((wst_q == W_IDLE) | (wst_q == W_GOT_A));
  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;

  // The commit edge may coincide with the final handshake, so bypass the capture regs.
  assign wa = aw_hs ? AWADDR : awaddr_q;
  assign wp = aw_hs ? AWPROT : awprot_q;
  assign wd = w_hs  ? WDATA  : wdata_q;
  assign ws = w_hs  ? WSTRB  : wstrb_q;

`ifdef AXIL_REG_PROT_CHECK_EN
  assign prot_err = ~wp[0];
`else
  logic unused_prot;
  assign unused_prot = ^wp;
  assign prot_err    = 1'b0;
`endif

  always_comb begin
    wst_d = wst_q;
    case (wst_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wst_d = W_RESP;
        else if (aw_hs)    wst_d = W_GOT_A;
        else if (w_hs)     wst_d = W_GOT_D;
      end
      W_GOT_A: if (w_hs)   wst_d = W_RESP;
      W_GOT_D: if (aw_hs)  wst_d = W_RESP;
      W_RESP:  if (BREADY) wst_d = W_IDLE;
      default:             wst_d = W_IDLE;
    endcase
  end

  assign commit  = (wst_q != W_RESP) && (wst_d == W_RESP);
  assign w_err   = addr_err(wa) | prot_err;
  assign bank_we = commit & ~w_err;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wst_q    <= W_IDLE;
      awaddr_q <= '0;
      awprot_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wst_q <= wst_d;
      if (aw_hs) begin
        awaddr_q <= AWADDR;
        awprot_q <= AWPROT;
      end
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      if (commit) bresp_q <= w_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign BVALID = (wst_q == W_RESP);
  assign BRESP  = bresp_q;

  rd_state_t             rst_q, rst_d;
  logic [DATA_WIDTH-1:0] rdata_q, bank_rdata;
  resp_t                 rresp_q;
  logic                  ar_hs, r_err;

  assign ARREADY = ~ARESET & (rst_q == R_IDLE);
  assign ar_hs   = ARVALID & ARREADY;
  assign r_err   = addr_err(ARADDR);

  always_comb begin
    rst_d = rst_q;
    case (rst_q)
      R_IDLE:  if (ar_hs)  rst_d = R_RESP;
      R_RESP:  if (RREADY) rst_d = R_IDLE;
      default:             rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rst_q   <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      rst_q <= rst_d;
      if (ar_hs) begin
        rdata_q <= r_err ? '0 : bank_rdata;
        rresp_q <= r_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign RVALID = (rst_q == R_RESP);
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

  axil_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RESET_VAL  (RESET_VAL)
  ) u_bank (
    .clk_i      (ACLK),
    .rst_i      (ARESET),
    .we_i       (bank_we),
    .widx_i     (wa[LSB +: IDX_W]),
    .wdata_i    (wd),
    .wstrb_i    (ws),
    .ridx_i     (ARADDR[LSB +: IDX_W]),
    .rdata_o    (bank_rdata),
    .regs_o     (regs_q),
    .wr_pulse_o (wr_pulse)
  );

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave (default parameters, 16 x 32-bit registers).
module tb_axil_reg_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID, RREADY;
  logic [511:0] regs_q;
  logic [15:0]  wr_pulse;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_regs [16];

  always #5 ACLK = ~ACLK;

  axil_reg_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (16),
    .RESET_VAL  (32'h0)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_q(regs_q), .wr_pulse(wr_pulse)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [511:0] flat_exp();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = exp_regs[i];
    return f;
  endfunction

  initial begin
    ARESET = 1'b1;
    AWADDR = '0; AWPROT = 3'b001; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    tick(); tick();

    // reset state
    chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("rst_valid", {BVALID, RVALID}, 2'b00);
    chk("rst_resp", {BRESP, RRESP, RDATA}, 36'h0);
    chk("rst_regs", regs_q, flat_exp());
    chk("rst_pulse", wr_pulse, 16'h0);
    ARESET = 1'b0;
    tick();

    // read reg 3 after reset
    ARADDR = 32'h0C; ARVALID = 1'b1;
    chk("rd3_arready", ARREADY, 1'b1);
    tick();
    ARVALID = 1'b0;
    chk("rd3_rvalid", {RVALID, ARREADY}, 2'b10);
    chk("rd3_data", {RRESP, RDATA}, {2'b00, 32'h0});
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk("rd3_done", {RVALID, ARREADY}, 2'b01);

    // AW at N, W at N+3, partial strobe
    AWADDR = 32'h08; AWVALID = 1'b1;
    chk("wr2_ready0", {AWREADY, WREADY}, 2'b11);
    tick();
    AWVALID = 1'b0;
    chk("wr2_gota", {AWREADY, WREADY, BVALID}, 3'b010);
    tick(); tick();
    chk("wr2_wait", {BVALID, wr_pulse}, 17'h0);
    WDATA = 32'hDEADBEEF; WSTRB = 4'b0011; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    exp_regs[2] = 32'h0000BEEF;
    chk("wr2_bvalid", {BVALID, BRESP}, 3'b100);
    chk("wr2_pulse", wr_pulse, 16'h0004);
    chk("wr2_regs", regs_q, flat_exp());
    tick();
    chk("wr2_pulse_off", {BVALID, wr_pulse}, {1'b1, 16'h0});
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("wr2_bdone", {BVALID, AWREADY, WREADY}, 3'b011);

    // W before AW, BREADY held low for 5 cycles
    WDATA = 32'hA5A55A5A; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    chk("wr4_gotd", {AWREADY, WREADY}, 2'b10);
    AWADDR = 32'h10; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    exp_regs[4] = 32'hA5A55A5A;
    chk("wr4_regs", regs_q, flat_exp());
    for (int i = 0; i < 5; i++) begin
      chk("wr4_hold", {BVALID, BRESP, AWREADY, WREADY}, 5'b10000);
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("wr4_bdone", BVALID, 1'b0);

    // low address bits ignored: 0x0B reads reg 2
    ARADDR = 32'h0B; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk("rd_lsb", {RVALID, RRESP, RDATA}, {1'b1, 2'b00, 32'h0000BEEF});
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;

    // out-of-range read
    ARADDR = 32'h40; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk("rd_err", {RVALID, RRESP, RDATA}, {1'b1, 2'b10, 32'h0});
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;

    // out-of-range write, AW and W together
    AWADDR = 32'h40; AWVALID = 1'b1;
    WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("wr_err_b", {BVALID, BRESP}, 3'b110);
    chk("wr_err_pulse", wr_pulse, 16'h0);
    chk("wr_err_regs", regs_q, flat_exp());
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;

    // zero strobe on valid reg: pulse fires, data kept
    AWADDR = 32'h10; AWVALID = 1'b1;
    WDATA = 32'h11111111; WSTRB = 4'h0; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("wr_zs_b", {BVALID, BRESP}, 3'b100);
    chk("wr_zs_pulse", wr_pulse, 16'h0010);
    chk("wr_zs_regs", regs_q, flat_exp());
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;

    // same-cycle write and read of reg 1
    AWADDR = 32'h04; AWVALID = 1'b1;
    WDATA = 32'h00001234; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 32'h04; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    exp_regs[1] = 32'h00001234;
    chk("rw_rdata_old", {RVALID, RDATA}, {1'b1, 32'h0});
    chk("rw_regs", regs_q, flat_exp());
    chk("rw_pulse", wr_pulse, 16'h0002);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    ARADDR = 32'h04; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk("rw_rdata_new", {RVALID, RRESP, RDATA}, {1'b1, 2'b00, 32'h00001234});
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;

`ifdef AXIL_REG_PROT_CHECK_EN
    AWADDR = 32'h14; AWPROT = 3'b000; AWVALID = 1'b1;
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("prot0_b", {BVALID, BRESP, wr_pulse}, {1'b1, 2'b10, 16'h0});
    chk("prot0_regs", regs_q, flat_exp());
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    AWPROT = 3'b001; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    exp_regs[5] = 32'hCAFEF00D;
    chk("prot1_b", {BVALID, BRESP, wr_pulse}, {1'b1, 2'b00, 16'h0020});
    chk("prot1_regs", regs_q, flat_exp());
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
